// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word stores into a local byte-lane data
// memory, sign/zero-extended loads, and a registered MEM/WB bundle with stall/flush/fault.
module mem_stage #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result_alu,
    input  logic [31:0] ex_rs2_final,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_func3,
    input  logic        stall,
    input  logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_result,
    output logic        wb_fault
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        offset;
    logic              acc_load;
    logic              acc_store;
    logic              size_ok;
    logic              align_ok;
    logic              fault_next;
    logic              advance;
    logic              bubble;
    logic [3:0]        lane_sel;
    logic [3:0]        lane_we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    logic              valid_reg;
    logic [4:0]        rd_dst_reg;
    logic              reg_write_reg;
    logic [31:0]       result_reg;
    logic              fault_reg;
    logic              load_reg;
    logic [2:0]        func3_reg;
    logic [1:0]        offset_reg;

    assign word_idx  = ex_result_alu[ADDR_W+1:2];
    assign offset    = ex_result_alu[1:0];
    assign acc_load  = ex_valid & ex_mem_read;
    assign acc_store = ex_valid & ex_mem_write;
    assign advance   = flush | ~stall;
    assign bubble    = flush | ~ex_valid;

    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        lane_sel = 4'b0000;
        wdata    = ex_rs2_final;
        case (ex_func3)
            3'b000:  size_ok = 1'b1;
            3'b001:  size_ok = 1'b1;
            3'b010:  size_ok = 1'b1;
            3'b100:  size_ok = ~acc_store;
            3'b101:  size_ok = ~acc_store;
            default: size_ok = 1'b0;
        endcase
        case (ex_func3[1:0])
            2'b00: begin
                align_ok = 1'b1;
                lane_sel = 4'b0001 << offset;
                wdata    = {4{ex_rs2_final[7:0]}};
            end
            2'b01: begin
                align_ok = ~offset[0];
                lane_sel = offset[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{ex_rs2_final[15:0]}};
            end
            2'b10: begin
                align_ok = (offset == 2'b00);
                lane_sel = 4'b1111;
            end
            default: align_ok = 1'b0;
        endcase
    end

    assign fault_next = (acc_load & acc_store) |
                        ((acc_load | acc_store) & ~(size_ok & align_ok));

    // A store is dropped while reset is high, even if the bundle is otherwise legal.
    always_comb begin
        lane_we = 4'b0000;
        if (advance && !bubble && acc_store && !fault_next && !rst)
            lane_we = lane_sel;
    end

    // One byte-wide memory per lane; the read port only advances with the stage so a stalled load holds its data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_reg;

        always_ff @(posedge clk) begin
            if (advance) begin
                lane_rd_reg <= lane_mem[word_idx];
                if (lane_we[gi])
                    lane_mem[word_idx] <= wdata[8*gi +: 8];
            end
        end

        assign rdata[8*gi +: 8] = lane_rd_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            rd_dst_reg    <= 5'd0;
            reg_write_reg <= 1'b0;
            result_reg    <= 32'd0;
            fault_reg     <= 1'b0;
            load_reg      <= 1'b0;
            func3_reg     <= 3'd0;
            offset_reg    <= 2'd0;
        end else if (advance) begin
            if (bubble) begin
                valid_reg     <= 1'b0;
                rd_dst_reg    <= 5'd0;
                reg_write_reg <= 1'b0;
                result_reg    <= 32'd0;
                fault_reg     <= 1'b0;
                load_reg      <= 1'b0;
            end else begin
                valid_reg  <= 1'b1;
                rd_dst_reg <= ex_rd;
                fault_reg  <= fault_next;
                load_reg   <= acc_load & ~fault_next;
                func3_reg  <= ex_func3;
                offset_reg <= offset;
                if (fault_next) begin
                    reg_write_reg <= 1'b0;
                    result_reg    <= 32'd0;
                end else if (acc_store) begin
                    reg_write_reg <= 1'b0;
                    result_reg    <= ex_result_alu;
                end else begin
                    reg_write_reg <= ex_reg_write;
                    result_reg    <= ex_result_alu;
                end
            end
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        byte_sel  = rdata[{offset_reg, 3'b000} +: 8];
        half_sel  = offset_reg[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (func3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    assign wb_valid     = valid_reg;
    assign wb_rd        = rd_dst_reg;
    assign wb_reg_write = reg_write_reg;
    assign wb_fault     = fault_reg;
    assign wb_result    = load_reg ? load_data : result_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written reset sequence, and
// randomized traffic checked against a byte-addressed reference model.
module tb_mem_stage;
    localparam int ADDR_W = 10;
    localparam int NBYTES = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result_alu = '0;
    logic [31:0] ex_rs2_final = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        wb_fault;

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result_alu(ex_result_alu),
        .ex_rs2_final(ex_rs2_final), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_func3(ex_func3),
        .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_result(wb_result), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic v; logic [4:0] rd; logic rw; logic mr; logic mw; logic [2:0] f3;
        logic [31:0] addr; logic [31:0] data; logic stall; logic flush;
        logic ev; logic [4:0] erd; logic erw; logic [31:0] eres; logic ef;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: byte-addressed memory and the expected MEM/WB bundle.
    logic [7:0]  mm [NBYTES];
    logic        m_v = 1'b0;
    logic [4:0]  m_rd = '0;
    logic        m_rw = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_f = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [4:0] rd,
                           input logic rw, input logic [31:0] res, input logic f);
        chk({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, v});
        chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, " wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, rw});
        chk({tag, " wb_result"}, wb_result, res);
        chk({tag, " wb_fault"}, {31'd0, wb_fault}, {31'd0, f});
        $display("%s: valid=%0b rd=%0d rw=%0b result=%08h fault=%0b",
                 tag, wb_valid, wb_rd, wb_reg_write, wb_result, wb_fault);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic st, input logic fl);
        ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_func3 = f3; ex_result_alu = addr; ex_rs2_final = data; stall = st; flush = fl;
    endtask

    function automatic vec_t mk(logic v, logic [4:0] rd, logic rw, logic mr, logic mw,
                                logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                                logic st, logic fl, logic ev, logic [4:0] erd, logic erw,
                                logic [31:0] eres, logic ef);
        vec_t t;
        t.v = v; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw; t.f3 = f3; t.addr = addr;
        t.data = data; t.stall = st; t.flush = fl; t.ev = ev; t.erd = erd; t.erw = erw;
        t.eres = eres; t.ef = ef;
        return t;
    endfunction

    // Expected behaviour from the access rules: size in bytes, alignment, little-endian bytes.
    task automatic model_step(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                              input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic st, input logic fl);
        int unsigned a;
        int size;
        bit legal;
        logic [31:0] val;
        if (st && !fl) begin
            // hold
        end else if (fl || !v) begin
            m_v = 1'b0; m_rd = '0; m_rw = 1'b0; m_res = '0; m_f = 1'b0;
        end else begin
            m_v = 1'b1; m_rd = rd; m_f = 1'b0;
            if (!mr && !mw) begin
                m_rw = rw; m_res = addr;
            end else begin
                a = addr % NBYTES;
                size = 1;
                legal = !(mr && mw);
                case (f3)
                    3'd0, 3'd4: size = 1;
                    3'd1, 3'd5: size = 2;
                    3'd2:       size = 4;
                    default:    legal = 1'b0;
                endcase
                if (mw && f3[2]) legal = 1'b0;
                if ((a % size) != 0) legal = 1'b0;
                if (!legal) begin
                    m_rw = 1'b0; m_res = '0; m_f = 1'b1;
                end else if (mw) begin
                    for (int i = 0; i < size; i++) mm[a + i] = data[8*i +: 8];
                    m_rw = 1'b0; m_res = addr;
                end else begin
                    val = '0;
                    for (int i = 0; i < size; i++) val = val | (32'(mm[a + i]) << (8*i));
                    if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
                    m_rw = rw; m_res = val;
                end
            end
        end
    endtask

    initial begin
        // v rd rw mr mw f3 addr data stall flush | ev erd erw eres ef
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h24, 32'h0000_0000, 0, 0, 1, 0, 0, 32'h24, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 32'h10, 0));
        tbl.push_back(mk(1, 5, 1, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 1, 5, 1, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b000, 32'h13, 32'hABCD_EF80, 0, 0, 1, 0, 0, 32'h13, 0));
        tbl.push_back(mk(1, 6, 1, 1, 0, 3'b000, 32'h13, 32'h0, 0, 0, 1, 6, 1, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(1, 7, 1, 1, 0, 3'b100, 32'h13, 32'h0, 0, 0, 1, 7, 1, 32'h0000_0080, 0));
        tbl.push_back(mk(1, 8, 1, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 1, 8, 1, 32'h80AD_BEEF, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b001, 32'h12, 32'h5555_1234, 0, 0, 1, 0, 0, 32'h12, 0));
        tbl.push_back(mk(1, 9, 1, 1, 0, 3'b101, 32'h12, 32'h0, 0, 0, 1, 9, 1, 32'h0000_1234, 0));
        tbl.push_back(mk(1, 10, 1, 1, 0, 3'b001, 32'h11, 32'h0, 0, 0, 1, 10, 0, 32'h0, 1));
        tbl.push_back(mk(1, 11, 1, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 1, 11, 1, 32'h1234_BEEF, 0));
        tbl.push_back(mk(1, 12, 1, 1, 0, 3'b010, 32'hFFFF_F010, 32'h0, 0, 0, 1, 12, 1, 32'h1234_BEEF, 0));
        tbl.push_back(mk(1, 13, 1, 0, 0, 3'b000, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 13, 1, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h24, 32'h2222_2222, 1, 0, 1, 13, 1, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h24, 32'h2222_2222, 1, 0, 1, 13, 1, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h20, 32'h1111_1111, 0, 0, 1, 0, 0, 32'h20, 0));
        tbl.push_back(mk(1, 14, 1, 1, 0, 3'b010, 32'h24, 32'h0, 0, 0, 1, 14, 1, 32'h0000_0000, 0));
        tbl.push_back(mk(1, 15, 1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 0, 1, 15, 1, 32'h1111_1111, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h20, 32'h5555_5555, 1, 1, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, 16, 1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 0, 1, 16, 1, 32'h1111_1111, 0));
        tbl.push_back(mk(1, 17, 1, 1, 1, 3'b010, 32'h20, 32'h6666_6666, 0, 0, 1, 17, 0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b100, 32'h20, 32'h0000_0077, 0, 0, 1, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b010, 32'h22, 32'h8888_8888, 0, 0, 1, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 18, 1, 1, 0, 3'b010, 32'h21, 32'h0, 0, 0, 1, 18, 0, 32'h0, 1));
        tbl.push_back(mk(1, 19, 1, 1, 0, 3'b011, 32'h20, 32'h0, 0, 0, 1, 19, 0, 32'h0, 1));
        tbl.push_back(mk(0, 20, 1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, 21, 1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 0, 1, 21, 1, 32'h1111_1111, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b001, 32'h16, 32'h0000_8001, 0, 0, 1, 0, 0, 32'h16, 0));
        tbl.push_back(mk(1, 22, 1, 1, 0, 3'b001, 32'h16, 32'h0, 0, 0, 1, 22, 1, 32'hFFFF_8001, 0));
        tbl.push_back(mk(1, 23, 1, 1, 0, 3'b000, 32'h11, 32'h0, 0, 0, 1, 23, 1, 32'hFFFF_FFBE, 0));
        tbl.push_back(mk(1, 24, 0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 1, 24, 0, 32'h1234_BEEF, 0));

        // Outputs must be zero while reset is held.
        #2;
        chk_all("reset", 0, 0, 0, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].f3,
                  tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].flush);
            @(posedge clk); #1;
            chk_all($sformatf("vec %0d", i), tbl[i].ev, tbl[i].erd, tbl[i].erw, tbl[i].eres, tbl[i].ef);
        end

        // Reset asserted mid-cycle while a store is presented: outputs clear at once, store is lost.
        drive(1, 0, 0, 0, 1, 3'b010, 32'h20, 32'h9999_9999, 0, 0);
        #3 rst = 1'b1;
        #1 chk_all("midrst async", 0, 0, 0, 32'h0, 0);
        @(posedge clk); #1;
        chk_all("midrst held", 0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        drive(1, 25, 1, 1, 0, 3'b010, 32'h20, 32'h0, 0, 0);
        @(posedge clk); #1;
        chk_all("post-rst LW", 1, 25, 1, 32'h1111_1111, 0);

        // Random traffic: prefill bytes 0..0xFF so the model knows every byte it may read.
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            drive(1, 0, 0, 0, 1, 3'b010, 32'(w * 4), d, 0, 0);
            model_step(1, 0, 0, 0, 1, 3'b010, 32'(w * 4), d, 0, 0);
            @(posedge clk); #1;
            chk_all($sformatf("fill %0d", w), m_v, m_rd, m_rw, m_res, m_f);
        end

        for (int n = 0; n < 400; n++) begin
            logic v, rw, mr, mw, st, fl;
            logic [4:0] rd;
            logic [2:0] f3;
            logic [31:0] addr, data;
            int op;
            op = $urandom_range(0, 9);
            mr = (op <= 3) || (op == 8);
            mw = (op >= 4 && op <= 6) || (op == 8);
            v  = ($urandom_range(0, 9) != 0);
            rw = $urandom_range(0, 1);
            rd = 5'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2));
            addr = (op == 7) ? $urandom : (($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)));
            data = $urandom;
            st = ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 9) == 0);
            drive(v, rd, rw, mr, mw, f3, addr, data, st, fl);
            model_step(v, rd, rw, mr, mw, f3, addr, data, st, fl);
            @(posedge clk); #1;
            chk_all($sformatf("rand %0d", n), m_v, m_rd, m_rw, m_res, m_f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
